// File: rtl/gray_conv_arbiter.sv
// rtl/gray_conv_arbiter.sv - round-robin arbiter sharing one registered Gray-to-binary converter
// Optional per-requester step checker (step_err port) enabled by GRAY_STEP_CHECK_EN.

module gray_conv_g2b #(
   parameter int WIDTH = 4
) (
   input  logic [WIDTH-1:0] gray,
   output logic [WIDTH-1:0] bin
);
   logic acc;

   // Running XOR from the MSB down: bin[i] = bin[i+1] ^ gray[i].
   always_comb begin
      bin = '0;
      acc = 1'b0;
      for (int i = WIDTH-1; i >= 0; i--) begin
         acc    = acc ^ gray[i];
         bin[i] = acc;
      end
   end
endmodule

module gray_conv_arbiter #(
   parameter int WIDTH = 4,
   parameter int NREQ  = 4,
   parameter int IDW   = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NREQ-1:0]       req_valid,
   input  logic [NREQ*WIDTH-1:0] req_gray,
   output logic [NREQ-1:0]       req_ready,
   output logic                  out_valid,
   output logic [WIDTH-1:0]      out_binary,
   output logic [IDW-1:0]        out_id,
   input  logic                  out_ready
`ifdef GRAY_STEP_CHECK_EN
   ,
   output logic                  step_err
`endif
);
   typedef enum logic [1:0] {IDLE, CONV, OUT} state_t;

   state_t           state;
   logic [IDW-1:0]   rr_ptr;
   logic [IDW-1:0]   grant;
   logic             grant_hit;
   logic [IDW:0]     cand;
   logic [IDW-1:0]   lat_id;
   logic [WIDTH-1:0] lat_gray;
   logic [WIDTH-1:0] conv_bin;
   logic [WIDTH-1:0] gray_arr [NREQ];

   always_comb begin
      for (int k = 0; k < NREQ; k++) begin
         gray_arr[k] = req_gray[k*WIDTH +: WIDTH];
      end
   end

   // First valid requester at or above rr_ptr, wrapping modulo NREQ.
   always_comb begin
      grant     = '0;
      grant_hit = 1'b0;
      cand      = '0;
      for (int i = 0; i < NREQ; i++) begin
         cand = {1'b0, rr_ptr} + (IDW+1)'(i);
         if (cand >= (IDW+1)'(NREQ)) begin
            cand = cand - (IDW+1)'(NREQ);
         end
         if (!grant_hit && req_valid[cand[IDW-1:0]]) begin
            grant     = cand[IDW-1:0];
            grant_hit = 1'b1;
         end
      end
   end

   always_comb begin
      req_ready = '0;
      if (!rst && state == IDLE && grant_hit) begin
         req_ready[grant] = 1'b1;
      end
   end

   gray_conv_g2b #(.WIDTH(WIDTH)) u_g2b (
      .gray (lat_gray),
      .bin  (conv_bin)
   );

`ifdef GRAY_STEP_CHECK_EN
   logic [WIDTH-1:0] last_bin [NREQ];
   logic [NREQ-1:0]  seen;
   logic [WIDTH-1:0] delta;
   logic             step_bad;

   // Only a +1 or -1 move (mod 2^WIDTH) from the previous word of the same requester is legal.
   assign delta    = conv_bin - last_bin[lat_id];
   assign step_bad = seen[lat_id] && (delta != WIDTH'(1)) && (delta != '1);
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         rr_ptr     <= '0;
         out_valid  <= 1'b0;
         out_binary <= '0;
         out_id     <= '0;
         lat_gray   <= '0;
         lat_id     <= '0;
`ifdef GRAY_STEP_CHECK_EN
         step_err   <= 1'b0;
         seen       <= '0;
         for (int k = 0; k < NREQ; k++) begin
            last_bin[k] <= '0;
         end
`endif
      end else begin
         case (state)
            IDLE: begin
               if (grant_hit) begin
                  lat_gray <= gray_arr[grant];
                  lat_id   <= grant;
                  rr_ptr   <= (grant == IDW'(NREQ-1)) ? '0 : grant + 1'b1;
                  state    <= CONV;
               end
            end
            CONV: begin
               out_binary <= conv_bin;
               out_id     <= lat_id;
               out_valid  <= 1'b1;
               state      <= OUT;
`ifdef GRAY_STEP_CHECK_EN
               step_err         <= step_bad;
               seen[lat_id]     <= 1'b1;
               last_bin[lat_id] <= conv_bin;
`endif
            end
            OUT: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  state     <= IDLE;
`ifdef GRAY_STEP_CHECK_EN
                  step_err  <= 1'b0;
`endif
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_gray_conv_arbiter.sv
// tb/tb_gray_conv_arbiter.sv - directed and randomized bench with a transaction-level reference model
// Step-check scenarios are included when GRAY_STEP_CHECK_EN is defined.

module tb_gray_conv_arbiter;
   localparam int WIDTH = 4;
   localparam int NREQ  = 4;
   localparam int IDW   = 2;

   logic                  clk = 1'b0;
   logic                  rst = 1'b1;
   logic [NREQ-1:0]       req_valid = '0;
   logic [NREQ*WIDTH-1:0] req_gray = '0;
   logic [NREQ-1:0]       req_ready;
   logic                  out_valid;
   logic [WIDTH-1:0]      out_binary;
   logic [IDW-1:0]        out_id;
   logic                  out_ready = 1'b0;
   logic                  dut_serr;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   gray_conv_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .IDW(IDW)) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_gray   (req_gray),
      .req_ready  (req_ready),
      .out_valid  (out_valid),
      .out_binary (out_binary),
      .out_id     (out_id),
      .out_ready  (out_ready)
`ifdef GRAY_STEP_CHECK_EN
      ,
      .step_err   (dut_serr)
`endif
   );

`ifndef GRAY_STEP_CHECK_EN
   assign dut_serr = 1'b0;
`endif

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Gray to binary as the XOR of all right shifts of the code word.
   function automatic logic [WIDTH-1:0] g2b(input logic [WIDTH-1:0] g);
      logic [WIDTH-1:0] b;
      b = g;
      for (int s = 1; s < WIDTH; s++) b = b ^ (g >> s);
      return b;
   endfunction

   // Reference model: one word in flight, timed by its accept cycle.
   typedef struct {int id; int bin; int serr; int cyc;} obs_t;
   obs_t             obs_q[$];
   int               cyc    = 0;
   bit               m_busy = 1'b0;
   int               m_acc  = 0;
   int               m_rr   = 0;
   int               m_id   = 0;
   logic [WIDTH-1:0] m_bin  = '0;
   bit               m_serr = 1'b0;
   logic [WIDTH-1:0] h_last [NREQ];
   bit               h_seen [NREQ];

   always @(negedge clk) begin
      logic [NREQ-1:0] exp_rdy;
      int g;
      int delta;
      bit valid_now;
      exp_rdy   = '0;
      g         = -1;
      valid_now = m_busy && (cyc >= m_acc + 2);
      if (!rst && !m_busy) begin
         for (int i = 0; i < NREQ; i++) begin
            if (g < 0 && req_valid[(m_rr + i) % NREQ]) g = (m_rr + i) % NREQ;
         end
      end
      if (g >= 0) exp_rdy[g] = 1'b1;
      chk("req_ready", req_ready, exp_rdy);
      chk("out_valid", out_valid, valid_now);
      if (valid_now) begin
         chk("out_binary", out_binary, m_bin);
         chk("out_id", out_id, m_id);
`ifdef GRAY_STEP_CHECK_EN
         chk("step_err", dut_serr, m_serr);
`endif
      end
      if (rst) begin
         m_busy = 1'b0;
         m_rr   = 0;
         for (int k = 0; k < NREQ; k++) begin
            h_seen[k] = 1'b0;
            h_last[k] = '0;
         end
      end else if (g >= 0) begin
         m_busy    = 1'b1;
         m_acc     = cyc;
         m_id      = g;
         m_rr      = (g + 1) % NREQ;
         m_bin     = g2b(req_gray[g*WIDTH +: WIDTH]);
         delta     = (int'(m_bin) - int'(h_last[g]) + (1 << WIDTH)) % (1 << WIDTH);
         m_serr    = h_seen[g] && delta != 1 && delta != (1 << WIDTH) - 1;
         h_seen[g] = 1'b1;
         h_last[g] = m_bin;
      end else if (valid_now && out_ready) begin
         obs_q.push_back('{int'(out_id), int'(out_binary), int'(dut_serr), cyc});
         m_busy = 1'b0;
      end
      cyc++;
   end

   task automatic set_gray(input int k, input logic [WIDTH-1:0] v);
      req_gray[k*WIDTH +: WIDTH] = v;
   endtask

   // Runs n cycles; each requester drops valid once its word is accepted.
   task automatic run(input int n);
      logic [NREQ-1:0] acc;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         acc = req_ready;
         @(posedge clk);
         #1;
         req_valid = req_valid & ~acc;
      end
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      rst       = 1'b1;
      req_valid = '0;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      obs_q.delete();
   endtask

   initial begin
      logic [NREQ-1:0] acc;

      // reset state
      do_reset();
      @(negedge clk);
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_out_id", out_id, 0);
      chk("rst_out_binary", out_binary, 0);
      chk("rst_req_ready", req_ready, 0);

      // single request, latency and return to idle
      @(posedge clk);
      #1;
      req_valid = 4'b0100;
      set_gray(2, 4'b1110);
      @(negedge clk);
      chk("t1_accept", req_ready, 4'b0100);
      @(posedge clk);
      #1;
      req_valid = '0;
      @(posedge clk);
      #1;
      @(negedge clk);
      chk("t1_valid", out_valid, 1'b1);
      chk("t1_bin", out_binary, 4'b1011);
      chk("t1_id", out_id, 2);
      @(posedge clk);
      #1;
      req_valid = 4'b0100;
      @(negedge clk);
      chk("t1_idle_again", req_ready, 4'b0100);
      run(4);

      // all four valid: order and cadence
      do_reset();
      set_gray(0, 4'b0011);
      set_gray(1, 4'b1100);
      set_gray(2, 4'b0101);
      set_gray(3, 4'b0001);
      req_valid = 4'b1111;
      run(14);
      chk("t2_count", obs_q.size(), 4);
      if (obs_q.size() >= 4) begin
         chk("t2_id0", obs_q[0].id, 0);
         chk("t2_bin0", obs_q[0].bin, 4'b0010);
         chk("t2_id1", obs_q[1].id, 1);
         chk("t2_bin1", obs_q[1].bin, 4'b1000);
         chk("t2_id2", obs_q[2].id, 2);
         chk("t2_bin2", obs_q[2].bin, 4'b0110);
         chk("t2_id3", obs_q[3].id, 3);
         chk("t2_bin3", obs_q[3].bin, 4'b0001);
         for (int i = 0; i < 3; i++) chk("t2_period", obs_q[i+1].cyc - obs_q[i].cyc, 3);
      end

      // backpressure
      do_reset();
      out_ready = 1'b0;
      set_gray(0, 4'b0110);
      set_gray(1, 4'b0011);
      req_valid = 4'b0011;
      run(2);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("t3_hold_valid", out_valid, 1'b1);
         chk("t3_hold_bin", out_binary, 4'b0100);
         chk("t3_hold_id", out_id, 0);
         chk("t3_no_accept", req_ready, 0);
         @(posedge clk);
         #1;
      end
      out_ready = 1'b1;
      @(negedge clk);
      chk("t3_drain_valid", out_valid, 1'b1);
      @(posedge clk);
      #1;
      @(negedge clk);
      chk("t3_drained", out_valid, 1'b0);
      chk("t3_next_grant", req_ready, 4'b0010);
      run(4);

      // wrap and fairness
      do_reset();
      set_gray(3, 4'b1000);
      req_valid = 4'b1000;
      run(4);
      set_gray(1, 4'b0111);
      set_gray(3, 4'b1001);
      req_valid = 4'b1010;
      run(8);
      chk("t4_count", obs_q.size(), 3);
      if (obs_q.size() >= 3) begin
         chk("t4_first", obs_q[0].id, 3);
         chk("t4_after_wrap", obs_q[1].id, 1);
         chk("t4_last", obs_q[2].id, 3);
      end

      // reset while holding a result
      do_reset();
      out_ready = 1'b0;
      set_gray(0, 4'b0101);
      set_gray(2, 4'b0110);
      req_valid = 4'b0101;
      run(3);
      @(negedge clk);
      chk("t5_in_out", out_valid, 1'b1);
      @(posedge clk);
      #1;
      rst       = 1'b1;
      req_valid = '0;
      @(posedge clk);
      #1;
      rst       = 1'b0;
      out_ready = 1'b1;
      obs_q.delete();
      set_gray(0, 4'b0010);
      set_gray(1, 4'b0111);
      req_valid = 4'b0011;
      @(negedge clk);
      chk("t5_valid_cleared", out_valid, 1'b0);
      chk("t5_id_cleared", out_id, 0);
      chk("t5_rr_cleared", req_ready, 4'b0001);
      run(4);
      chk("t5_served", obs_q.size() >= 1, 1'b1);
      if (obs_q.size() >= 1) begin
         chk("t5_id", obs_q[0].id, 0);
         chk("t5_bin", obs_q[0].bin, 4'b0011);
      end
      run(4);

`ifdef GRAY_STEP_CHECK_EN
      // step checker on requester 1
      do_reset();
      set_gray(1, 4'b0001);
      req_valid = 4'b0010;
      run(4);
      set_gray(1, 4'b0011);
      req_valid = 4'b0010;
      run(4);
      set_gray(1, 4'b0110);
      req_valid = 4'b0010;
      run(4);
      chk("t6_count", obs_q.size(), 3);
      if (obs_q.size() >= 3) begin
         chk("t6_err0", obs_q[0].serr, 0);
         chk("t6_err1", obs_q[1].serr, 0);
         chk("t6_err2", obs_q[2].serr, 1);
      end
      do_reset();
      set_gray(1, 4'b0110);
      req_valid = 4'b0010;
      run(4);
      chk("t6_post_rst_count", obs_q.size(), 1);
      if (obs_q.size() >= 1) chk("t6_post_rst_err", obs_q[0].serr, 0);
`endif

      // randomized traffic, model checks every cycle
      do_reset();
      for (int n = 0; n < 3000; n++) begin
         @(negedge clk);
         acc = req_ready;
         @(posedge clk);
         #1;
         for (int k = 0; k < NREQ; k++) begin
            if (acc[k] || !req_valid[k]) begin
               req_valid[k] = 1'($urandom_range(0, 1));
               set_gray(k, WIDTH'($urandom));
            end else if ($urandom_range(0, 9) == 0) begin
               req_valid[k] = 1'b0;
            end
         end
         out_ready = ($urandom_range(0, 3) != 0);
         rst       = ($urandom_range(0, 499) == 0);
      end
      rst = 1'b0;
      run(4);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: run exceeded time limit, total=%0d bad=%0d", total, bad);
      $fatal(1);
   end
endmodule
